// File: rtl/mem_pkg.sv
// Shared types for the two-port memory arbiter: FSM states, port identifiers,
// the wait-counter width and the round-robin grant decision.
package mem_pkg;

  localparam int WAIT_CYCLES_DEFAULT = 3;
  localparam int CNT_W               = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_D  = 1'b1
  } port_t;

  // On contention the port that did not win last time gets the bus.
  function automatic port_t arbitrate(input logic if_req, input logic d_req,
                                      input port_t last);
    if (if_req && d_req) return (last == PORT_IF) ? PORT_D : PORT_IF;
    else if (d_req)      return PORT_D;
    else                 return PORT_IF;
  endfunction

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter that times how long an access holds the memory bus;
// it saturates at zero and flags zero combinationally.
module wait_counter
  import mem_pkg::*;
#(
  parameter int WIDTH = CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q, count_d;

  // NOTE: count_d takes a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one wait-state memory between an instruction
// fetch port and a load/store data port over a tri-state data bus.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT  // 1..15, must cover the memory access time
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_ack,
  output logic [15:0] mem_addr,
  output logic        mem_load,
  output logic        mem_store,
  inout  wire  [15:0] mem_data
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  port_t             grant_q;
  port_t             pick;
  logic [15:0]       addr_q, wdata_q, if_rdata_q, d_rdata_q;
  logic              we_q;
  logic              accept, busy, cnt_zero, drive_bus;
  logic [CNT_W-1:0]  cnt;

  assign accept = (state_q == IDLE) && (if_req || d_req);
  assign busy   = (state_q == READ) || (state_q == WRITE);
  assign pick   = arbitrate(if_req, d_req, grant_q);

  wait_counter #(.WIDTH(CNT_W)) u_wait (
    .clk        (clk),
    .reset      (reset),
    .load_i     (accept),
    .load_val_i (LOAD_VAL),
    .dec_i      (busy),
    .count_o    (cnt),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (accept) state_d = ((pick == PORT_D) && d_we) ? WRITE : READ;
      READ, WRITE: if (cnt_zero) state_d = DONE;
      DONE:        state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // grant_q doubles as the last-granted port for the next contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q    <= PORT_IF;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (accept) begin
        grant_q <= pick;
        if (pick == PORT_D) begin
          addr_q  <= d_addr;
          wdata_q <= d_wdata;
          we_q    <= d_we;
        end else begin
          addr_q  <= if_addr;
          we_q    <= 1'b0;
        end
      end
      if ((state_q == READ) && cnt_zero) begin
        if (grant_q == PORT_D) d_rdata_q  <= mem_data;
        else                   if_rdata_q <= mem_data;
      end
    end
  end

  always_comb begin
    mem_load  = 1'b0;
    mem_store = 1'b0;
    drive_bus = 1'b0;
    if_ack    = 1'b0;
    d_ack     = 1'b0;
    case (state_q)
      READ:  mem_load = 1'b1;
      WRITE: begin
        mem_store = (cnt == LOAD_VAL);  // strobe only on the first write cycle
        drive_bus = 1'b1;
      end
      DONE: begin
        drive_bus = we_q;
        if_ack    = (grant_q == PORT_IF);
        d_ack     = (grant_q == PORT_D);
      end
      default: ;
    endcase
  end

  assign mem_data = drive_bus ? wdata_q : 16'hzzzz;
  assign mem_addr = addr_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

endmodule
